// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths and the fetch FSM state encoding.
package cpu_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_WAIT    = 2'b01;
  localparam logic [1:0] ST_DISCARD = 2'b10;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction FIFO with push, pop, flush and occupancy count.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 20
) (
  input  logic                     clk1,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk1) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding memory requester feeding a FIFO.
// Optional stall counter enabled by defining FETCH_QUEUE_STALL_CNT_EN.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk1,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               instr_ready,
  output logic [15:0]        stall_cnt
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int QW = INSTR_W + PC_W;

  logic [1:0]      state;
  logic [PC_W-1:0] pc;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push;
  logic            pop;
  logic [QW-1:0]   head;

  // Redirect wins over both queue ports: flush, no push, no pop.
  assign pop  = instr_valid && instr_ready && !redirect;
  assign push = (state == ST_WAIT) && imem_ack && !redirect && !fifo_full;

  assign instr_valid = !fifo_empty;
  assign instr_out   = head[QW-1:PC_W];
  assign instr_pc    = head[PC_W-1:0];

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (QW)
  ) u_fifo (
    .clk1      (clk1),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rdata, imem_addr}),
    .pop       (pop),
    .flush     (redirect),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (fifo_count < CW'(DEPTH)) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
            pc       <= redirect ? redirect_pc : pc + PC_W'(1);
          end else if (redirect) begin
            pc    <= redirect_pc;
            state <= ST_DISCARD;
          end
        end
        // The in-flight response belongs to the old stream and is dropped.
        ST_DISCARD: begin
          if (redirect) pc <= redirect_pc;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (instr_ready && !instr_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory responder and a queue model track every fetch.
module tb_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } ent_t;

  logic               clk1;
  logic               reset;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic [15:0]        stall_cnt;

  int errors = 0;
  int checks = 0;

  ent_t            exp_q[$];
  logic            outst;
  logic            taint;
  logic            after_rst;
  int              wcnt;
  int              lat;
  logic            ready_val;
  logic            redir_req;
  logic [PC_W-1:0] redir_pc;
  logic [PC_W-1:0] exp_pc;
  logic [PC_W-1:0] out_addr;
  logic [15:0]     exp_stall;
  logic            ok;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clk1        (clk1),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .stall_cnt   (stall_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, then drive inputs and
  // advance the model to what the next rising edge should produce.
  task automatic step();
    logic ack_now;
    ent_t e;
    @(negedge clk1);
    chk("valid", 32'(instr_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("head_instr", 32'(instr_out), 32'(exp_q[0].instr));
      chk("head_pc", 32'(instr_pc), 32'(exp_q[0].pc));
    end
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`else
    chk("stall_zero", 32'(stall_cnt), 32'h0);
`endif
    if (after_rst) begin
      chk("first_req", 32'(imem_req), 32'h1);
      after_rst = 1'b0;
    end
    if (outst) begin
      chk("req_hold", 32'(imem_req), 32'h1);
      chk("addr_hold", 32'(imem_addr), 32'(out_addr));
    end else if (imem_req) begin
      chk("req_addr", 32'(imem_addr), 32'(exp_pc));
      chk("req_space", 32'(exp_q.size() < DEPTH), 32'h1);
      outst    = 1'b1;
      taint    = 1'b0;
      out_addr = imem_addr;
      wcnt     = lat;
    end
    ack_now = 1'b0;
    if (outst) begin
      if (wcnt == 0) ack_now = 1'b1;
      else wcnt--;
    end
    imem_ack    = ack_now;
    imem_rdata  = 16'($urandom);
    redirect    = redir_req;
    redirect_pc = redir_pc;
    instr_ready = ready_val;
    if (ready_val && exp_q.size() == 0 && exp_stall != 16'hFFFF) exp_stall++;
    if (redir_req) begin
      exp_q.delete();
      exp_pc = redir_pc;
      if (outst) taint = 1'b1;
    end else if (ready_val && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    if (ack_now) begin
      if (!taint && !redir_req) begin
        e.instr = imem_rdata;
        e.pc    = out_addr;
        exp_q.push_back(e);
        exp_pc = out_addr + 4'd1;
      end
      outst = 1'b0;
    end
    redir_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    reset = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    exp_q.delete();
    outst     = 1'b0;
    taint     = 1'b0;
    exp_pc    = '0;
    exp_stall = '0;
    redir_req = 1'b0;
    repeat (2) @(negedge clk1);
    // Release with a stray ack present: nothing is outstanding, so it must be ignored.
    reset       = 1'b1;
    imem_ack    = 1'b1;
    imem_rdata  = 16'hDEAD;
    redirect    = 1'b0;
    instr_ready = ready_val;
    if (ready_val) exp_stall++;
    after_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    outst       = 1'b0;
    taint       = 1'b0;
    after_rst   = 1'b0;
    wcnt        = 0;
    lat         = 1;
    ready_val   = 1'b1;
    redir_req   = 1'b0;
    redir_pc    = '0;
    exp_pc      = '0;
    out_addr    = '0;
    exp_stall   = '0;

    // Streaming fetch with pc wrap
    do_reset();
    repeat (60) step();

    // Back-pressure until full, drain, then redirect in IDLE with a pop attempt
    ready_val = 1'b0;
    repeat (14) step();
    chk("full_noreq", 32'(imem_req), 32'h0);
    ready_val = 1'b1;
    repeat (20) step();
    ready_val = 1'b0;
    repeat (14) step();
    ready_val = 1'b1;
    redir_req = 1'b1;
    redir_pc  = 4'h7;
    repeat (12) step();

    // Redirect while waiting, late ack dropped
    lat = 3;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outst && !taint) begin ok = 1'b1; break; end
    end
    chk("reach_wait_a", 32'(ok), 32'h1);
    redir_req = 1'b1;
    redir_pc  = 4'hA;
    repeat (15) step();

    // Two redirects while discarding: only the last pc counts
    lat = 4;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outst && !taint) begin ok = 1'b1; break; end
    end
    chk("reach_wait_b", 32'(ok), 32'h1);
    redir_req = 1'b1;
    redir_pc  = 4'h5;
    step();
    redir_req = 1'b1;
    redir_pc  = 4'h9;
    repeat (15) step();

    // Redirect coincident with ack
    lat = 2;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (outst && !taint && wcnt == 0) begin ok = 1'b1; break; end
    end
    chk("reach_ack", 32'(ok), 32'h1);
    redir_req = 1'b1;
    redir_pc  = 4'h3;
    repeat (12) step();

    // Slow memory with a hungry decoder
    lat = 5;
    repeat (40) step();

    // Reset mid-request with two entries queued
    lat       = 1;
    ready_val = 1'b0;
    ok        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (outst && exp_q.size() == 2) begin ok = 1'b1; break; end
    end
    chk("reach_two", 32'(ok), 32'h1);
    ready_val = 1'b1;
    do_reset();
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of instruction queue entries (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 4, meaning program-counter width.
REQ-003 SHALL have parameter INSTR_W, default 16, meaning instruction width.
REQ-004 clk1  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 imem_req  output  1  instruction-memory read request.
REQ-007 imem_addr  output  PC_W  address of the requested instruction.
REQ-008 imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle.
REQ-009 imem_rdata  input  INSTR_W  instruction returned by memory.
REQ-010 redirect  input  1  one-cycle flush-and-jump command.
REQ-011 redirect_pc  input  PC_W  new fetch address, sampled when redirect=1.
REQ-012 instr_valid  output  1  queue head holds a valid instruction for the decoder.
REQ-013 instr_out  output  INSTR_W  instruction at the queue head.
REQ-014 instr_pc  output  PC_W  address of instr_out.
REQ-015 instr_ready  input  1  decoder accepts the head this cycle.
REQ-016 stall_cnt  output  16  decoder-starved cycle count.

Function
REQ-017 The FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding), and DISCARD (request outstanding, its data to be dropped).
REQ-018 In IDLE, the block SHALL raise imem_req with imem_addr=pc and enter WAIT when queue count < DEPTH and redirect=0; otherwise it SHALL stay in IDLE.
REQ-019 imem_req and imem_addr SHALL stay constant from issue until the cycle imem_ack=1; there SHALL be at most one outstanding request.
REQ-020 In WAIT, when imem_ack=1 and redirect=0, the block SHALL write {imem_rdata, imem_addr} into the queue, set pc to pc+1 modulo 2^PC_W (wrap 15->0), drop imem_req, and return to IDLE.
REQ-021 A pop SHALL occur when instr_valid && instr_ready; instr_out and instr_pc SHALL always show the oldest entry.
REQ-022 A simultaneous push and pop SHALL leave count unchanged and SHALL be legal at full and at empty+1.
REQ-023 Data acked in cycle N SHALL be visible at the head no earlier than cycle N+1; there is no combinational path from imem_rdata to instr_out.
REQ-024 Redirect SHALL empty the queue, load pc with redirect_pc, and deassert instr_valid in the next cycle; a pop in the same cycle SHALL be ignored.
REQ-025 Redirect in WAIT without ack SHALL move the FSM to DISCARD, keeping imem_req high.
REQ-026 Redirect in the same cycle as imem_ack SHALL drop that data and move the FSM to IDLE.
REQ-027 In DISCARD, imem_ack SHALL drop the data, leave pc unchanged, and move the FSM to IDLE; a further redirect SHALL only reload pc.
REQ-028 Redirect in IDLE SHALL load pc and suppress issue in that cycle.

Reset
REQ-029 While reset=0, the block SHALL set state=IDLE, pc=0, count=0, imem_req=0, imem_addr=0, instr_valid=0, and stall_cnt=0.
REQ-030 Reset mid-request SHALL abandon the request; an imem_ack arriving after reset release with no request outstanding SHALL be ignored.
REQ-031 The first imem_req SHALL rise on the first clk1 edge after reset deasserts.

Configuration
REQ-032 With FETCH_QUEUE_STALL_CNT_EN defined, stall_cnt SHALL increment, saturating at 16'hFFFF, in every cycle with instr_ready=1 and instr_valid=0.
REQ-033 Without FETCH_QUEUE_STALL_CNT_EN, stall_cnt SHALL be constant 0, no counter flops SHALL exist, and the port SHALL remain.

Structure
REQ-034 The shared package cpu_pkg SHALL hold PC_W, INSTR_W, and the fetch FSM state encoding (IDLE=2'b00, WAIT=2'b01, DISCARD=2'b10).
REQ-035 Queue storage SHALL be a sub-module fetch_fifo (synchronous FIFO with push, pop, flush, full, empty, and count); the FSM and pc SHALL live in fetch_queue.

Verification
REQ-036 Reset release, memory acking 1 cycle after req, instr_ready=1 -> addresses 0,1,2,... issued; instr_pc sequence 0,1,2 with matching imem_rdata; pc wraps 15->0.
REQ-037 instr_ready=0 for 10 cycles -> exactly 4 entries queued, imem_req stays 0 with count=4; instr_ready=1 -> pops in order with no loss or duplication.
REQ-038 Redirect to 4'hA while WAIT, ack 3 cycles later -> acked data never appears; next request addr=4'hA; instr_valid=0 the cycle after redirect.
REQ-039 Redirect to 4'h3 coincident with imem_ack -> data dropped, FSM IDLE, next imem_addr=4'h3.
REQ-040 Ack latency 5, instr_ready=1, macro defined -> stall_cnt increments each empty cycle; without macro -> stall_cnt=0 throughout.
REQ-041 reset=0 asserted while WAIT with queue holding 2 entries -> instr_valid=0 and imem_req=0 immediately; after release, first addr=0.
